// File: rtl/alu_op_scheduler_pkg.sv
// Shared opcode constants, scheduler state encoding and the opcode-to-latency lookup
// for the ALU operation scheduler.
package alu_op_scheduler_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } sched_state_t;

  function automatic int unsigned op_latency(
    input logic [2:0]  op,
    input int unsigned lat_basic,
    input int unsigned lat_add,
    input int unsigned lat_mult
  );
    case (op)
      OP_ADD:  return lat_add;
      OP_MUL:  return lat_mult;
      default: return lat_basic;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins; on contention the port that
// was not served last wins. Purely combinational, one-hot grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Time-shares one 8-bit ALU between two requesters: round-robin grant, operands held
// on the ALU for an opcode-dependent wait, result returned on a valid/ready response.
module alu_op_scheduler
  import alu_op_scheduler_pkg::*;
#(
  parameter int unsigned LAT_BASIC = 1,
  parameter int unsigned LAT_ADD   = 1,
  parameter int unsigned LAT_MULT  = 3,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [2:0] REQ0_OP,
  input  logic [7:0] REQ0_A,
  input  logic [7:0] REQ0_B,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [2:0] REQ1_OP,
  input  logic [7:0] REQ1_A,
  input  logic [7:0] REQ1_B,
  output logic       RSP0_VALID,
  input  logic       RSP0_READY,
  output logic       RSP1_VALID,
  input  logic       RSP1_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ZERO,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO,
  output logic       BUSY
);

  localparam int unsigned LAT_MAX =
    (LAT_MULT > LAT_ADD) ? ((LAT_MULT > LAT_BASIC) ? LAT_MULT : LAT_BASIC)
                         : ((LAT_ADD  > LAT_BASIC) ? LAT_ADD  : LAT_BASIC);

  if (LAT_BASIC == 0 || LAT_ADD == 0 || LAT_MULT == 0 ||
      (LAT_MAX - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("alu_op_scheduler: LAT_* must be >= 1 and CNT_W must hold max(LAT_*)-1");
  end

  sched_state_t     state;
  logic [1:0]       grant;
  logic             rr_favour;
  logic             last_served;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic [2:0]       sel_op;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic             owner_ready;
  logic [7:0]       alu_data1_q;
  logic [7:0]       alu_data2_q;
  logic [2:0]       alu_select_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;

  // rr_favour resets to 0 so port 0 wins the first contention after reset.
  assign last_served = ~rr_favour;

  rr_arbiter2 u_arb (
    .req   ({REQ1_VALID, REQ0_VALID}),
    .last  (last_served),
    .grant (grant)
  );

  always_comb begin
    sel_op = REQ0_OP;
    sel_a  = REQ0_A;
    sel_b  = REQ0_B;
    if (grant[1]) begin
      sel_op = REQ1_OP;
      sel_a  = REQ1_A;
      sel_b  = REQ1_B;
    end
  end

  assign cnt_load    = CNT_W'(op_latency(sel_op, LAT_BASIC, LAT_ADD, LAT_MULT) - 1);
  assign owner_ready = owner ? RSP1_READY : RSP0_READY;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      rr_favour    <= 1'b0;
      owner        <= 1'b0;
      cnt          <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_select_q <= sel_op;
            alu_data1_q  <= sel_a;
            alu_data2_q  <= sel_b;
            owner        <= grant[1];
            rr_favour    <= grant[0];
            cnt          <= cnt_load;
            busy_q       <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data_q   <= ALU_RESULT;
            // The ALU only refreshes ZERO on add; elsewhere it is stale.
            rsp_zero_q   <= (alu_select_q == OP_ADD) && ALU_ZERO;
            rsp0_valid_q <= ~owner;
            rsp1_valid_q <= owner;
            state        <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (owner_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gating keeps READY low while RESET is held even if a requester is valid.
  assign REQ0_READY = RESET && (state == IDLE) && grant[0];
  assign REQ1_READY = RESET && (state == IDLE) && grant[1];
  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ZERO   = rsp_zero_q;
  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_SELECT = alu_select_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: behavioural ALU, scoreboard of expected
// responses, and per-scenario tasks checking handshake, latency and arbitration.
module tb_alu_op_scheduler;
  import alu_op_scheduler_pkg::*;

  localparam int LAT_B = 1;
  localparam int LAT_A = 1;
  localparam int LAT_M = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic       REQ0_READY, REQ1_READY;
  logic [2:0] REQ0_OP = '0, REQ1_OP = '0;
  logic [7:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic       RSP0_VALID, RSP1_VALID;
  logic       RSP0_READY = 1'b0, RSP1_READY = 1'b0;
  logic [7:0] RSP_DATA;
  logic       RSP_ZERO;
  logic [7:0] ALU_DATA1, ALU_DATA2;
  logic [2:0] ALU_SELECT;
  logic [7:0] ALU_RESULT;
  logic       ALU_ZERO;
  logic       BUSY;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  alu_op_scheduler #(
    .LAT_BASIC (LAT_B),
    .LAT_ADD   (LAT_A),
    .LAT_MULT  (LAT_M),
    .CNT_W     (3)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_OP    (REQ0_OP),
    .REQ0_A     (REQ0_A),
    .REQ0_B     (REQ0_B),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_OP    (REQ1_OP),
    .REQ1_A     (REQ1_A),
    .REQ1_B     (REQ1_B),
    .RSP0_VALID (RSP0_VALID),
    .RSP0_READY (RSP0_READY),
    .RSP1_VALID (RSP1_VALID),
    .RSP1_READY (RSP1_READY),
    .RSP_DATA   (RSP_DATA),
    .RSP_ZERO   (RSP_ZERO),
    .ALU_DATA1  (ALU_DATA1),
    .ALU_DATA2  (ALU_DATA2),
    .ALU_SELECT (ALU_SELECT),
    .ALU_RESULT (ALU_RESULT),
    .ALU_ZERO   (ALU_ZERO),
    .BUSY       (BUSY)
  );

  // Behavioural ALU; ZERO follows every result so masking of non-add ZERO is visible.
  logic [15:0] ror_tmp;
  always_comb begin
    ror_tmp    = {ALU_DATA1, ALU_DATA1} >> ALU_DATA2[2:0];
    ALU_RESULT = ALU_DATA1;
    case (ALU_SELECT)
      OP_FWD: ALU_RESULT = ALU_DATA1;
      OP_ADD: ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      OP_AND: ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      OP_OR:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      OP_SLL: ALU_RESULT = ALU_DATA1 << ALU_DATA2[2:0];
      OP_SRA: ALU_RESULT = $unsigned($signed(ALU_DATA1) >>> ALU_DATA2[2:0]);
      OP_ROR: ALU_RESULT = ror_tmp[7:0];
      OP_MUL: ALU_RESULT = 8'(ALU_DATA1 * ALU_DATA2);
      default: ALU_RESULT = ALU_DATA1;
    endcase
    ALU_ZERO = (ALU_RESULT == 8'h00);
  end

  // Scoreboard: pops one expectation per response handshake, sampled mid-low-phase.
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (RESET && ((RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY))) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got port %0d data %h zero %0d, required no response",
                 RSP1_VALID, RSP_DATA, RSP_ZERO);
      end else begin
        e = sb.pop_front();
        if (RSP1_VALID !== e.port || RSP0_VALID !== ~e.port ||
            RSP_DATA !== e.data || RSP_ZERO !== e.zero) begin
          miscompares++;
          $display("FAIL sb_response: got port %0d data %h zero %0d, required port %0d data %h zero %0d",
                   RSP1_VALID, RSP_DATA, RSP_ZERO, e.port, e.data, e.zero);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input bit port, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
    if (!port) begin
      REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
    end else begin
      REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
    end
  endtask

  task automatic push_exp(input bit port, input logic [7:0] data, input logic zero);
    exp_t e;
    e.port = port; e.data = data; e.zero = zero;
    sb.push_back(e);
  endtask

  // Waits (from a negedge) until the port's READY is high; accept is the next posedge.
  task automatic wait_ready(input bit port, output int cyc);
    cyc = 0;
    #1;
    while ((port ? REQ1_READY : REQ0_READY) !== 1'b1) begin
      if (cyc >= 50) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: port %0d READY=0 after %0d cycles, required 1", port, cyc);
        cyc = -1;
        return;
      end
      @(negedge CLK); #1;
      cyc++;
    end
  endtask

  // Called just before accept edge E0; returns edges from E0 until RSP valid is seen.
  task automatic wait_rsp(input bit port, output int lat);
    lat = 0;
    forever begin
      @(negedge CLK);
      if (lat == 0) begin
        if (!port) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
      end
      #1;
      if ((port ? RSP1_VALID : RSP0_VALID) === 1'b1) return;
      lat++;
      if (lat > 50) begin
        vectors++; miscompares++;
        $display("FAIL rsp_timeout: port %0d RSP_VALID=0 after %0d cycles, required 1", port, lat);
        lat = -1;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    RESET = 1'b0;
    #12;
    outs = {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_ZERO, BUSY,
            RSP_DATA, ALU_DATA1, ALU_DATA2, ALU_SELECT};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_add_basic();
    int c, lat;
    @(negedge CLK);
    RSP0_READY = 1'b1;
    drive_req(0, OP_ADD, 8'd5, 8'd3);
    #1;
    vectors++;
    if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ready: got r0=%0d r1=%0d, required r0=1 r1=0", REQ0_READY, REQ1_READY);
    end
    wait_ready(0, c);
    push_exp(0, 8'd8, 1'b0);
    wait_rsp(0, lat);
    vectors++;
    if (lat != LAT_A || RSP1_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL add_latency: got %0d rsp1=%0d, required %0d rsp1=0", lat, RSP1_VALID, LAT_A);
    end
    @(negedge CLK); #1;
    vectors++;
    if (BUSY !== 1'b0 || RSP0_VALID !== 1'b0 || ALU_DATA1 !== 8'd5 ||
        ALU_DATA2 !== 8'd3 || ALU_SELECT !== OP_ADD) begin
      miscompares++;
      $display("FAIL add_after: got busy=%0d v0=%0d alu=%h/%h/%0d, required 0 0 05/03/1",
               BUSY, RSP0_VALID, ALU_DATA1, ALU_DATA2, ALU_SELECT);
    end
  endtask

  task automatic test_zero_flag();
    int c, lat;
    @(negedge CLK);
    RSP1_READY = 1'b1;
    drive_req(1, OP_ADD, 8'h80, 8'h80);
    wait_ready(1, c);
    push_exp(1, 8'h00, 1'b1);
    wait_rsp(1, lat);
    vectors++;
    if (lat != LAT_A || RSP0_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_owner: got lat=%0d rsp0=%0d, required lat=%0d rsp0=0", lat, RSP0_VALID, LAT_A);
    end
    @(negedge CLK);
  endtask

  task automatic test_round_robin();
    int c, lat;
    apply_reset();
    RSP0_READY = 1'b1; RSP1_READY = 1'b1;
    for (int round = 0; round < 2; round++) begin
      drive_req(0, OP_OR,  8'h0F, 8'hF0);
      drive_req(1, OP_AND, 8'h0F, 8'hF0);
      #1;
      vectors++;
      if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_first_round%0d: got r0=%0d r1=%0d, required r0=1 r1=0",
                 round, REQ0_READY, REQ1_READY);
      end
      push_exp(0, 8'hFF, 1'b0);
      push_exp(1, 8'h00, 1'b0);
      wait_rsp(0, lat);
      vectors++;
      if (lat != LAT_B || REQ1_READY !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_port0_round%0d: got lat=%0d r1=%0d, required lat=%0d r1=0",
                 round, lat, REQ1_READY, LAT_B);
      end
      @(negedge CLK);
      wait_ready(1, c);
      vectors++;
      if (c != 0) begin
        miscompares++;
        $display("FAIL rr_port1_wait_round%0d: got %0d cycles, required 0", round, c);
      end
      wait_rsp(1, lat);
      @(negedge CLK);
    end
  endtask

  task automatic test_mul_latency();
    int c, lat;
    RSP0_READY = 1'b1;
    drive_req(0, OP_MUL, 8'd7, 8'd6);
    wait_ready(0, c);
    push_exp(0, 8'd42, 1'b0);
    wait_rsp(0, lat);
    vectors++;
    if (lat != LAT_M) begin
      miscompares++;
      $display("FAIL mul_latency: got %0d edges, required %0d", lat, LAT_M);
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int c, lat;
    logic [11:0] obs;
    RSP0_READY = 1'b0; RSP1_READY = 1'b1;
    drive_req(0, OP_ADD, 8'h10, 8'h20);
    wait_ready(0, c);
    push_exp(0, 8'h30, 1'b0);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    drive_req(1, OP_FWD, 8'h55, 8'h00);
    push_exp(1, 8'h55, 1'b0);
    c = 0;
    #1;
    while (RSP0_VALID !== 1'b1 && c < 50) begin
      @(negedge CLK); #1; c++;
    end
    for (int i = 0; i < 5; i++) begin
      obs = {RSP0_VALID, RSP1_VALID, REQ1_READY, RSP_ZERO, RSP_DATA};
      vectors++;
      if (obs !== {4'b1000, 8'h30}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v0/v1/r1/z/data=%h, required 830", i, obs);
      end
      @(negedge CLK); #1;
    end
    RSP0_READY = 1'b1;
    vectors++;
    if (REQ1_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_same_edge: got REQ1_READY=%0d, required 0", REQ1_READY);
    end
    @(negedge CLK); #1;
    vectors++;
    if (REQ1_READY !== 1'b1 || RSP0_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_accept: got r1=%0d v0=%0d, required r1=1 v0=0", REQ1_READY, RSP0_VALID);
    end
    wait_rsp(1, lat);
    vectors++;
    if (lat != LAT_B) begin
      miscompares++;
      $display("FAIL bp_req1_latency: got %0d, required %0d", lat, LAT_B);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_wait();
    int c, lat, stray;
    logic [32:0] outs;
    RSP0_READY = 1'b1;
    drive_req(0, OP_MUL, 8'd9, 8'd9);
    wait_ready(0, c);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    outs = {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_ZERO, BUSY,
            RSP_DATA, ALU_DATA1, ALU_DATA2, ALU_SELECT};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %h, required 0", outs);
    end
    @(negedge CLK);
    RESET = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); #1;
      if (RSP0_VALID !== 1'b0 || RSP1_VALID !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL reset_drop: got %0d cycles with activity, required 0", stray);
    end
    @(negedge CLK);
    drive_req(0, OP_ADD, 8'hFF, 8'h01);
    wait_ready(0, c);
    push_exp(0, 8'h00, 1'b1);
    wait_rsp(0, lat);
    vectors++;
    if (lat != LAT_A || c != 0) begin
      miscompares++;
      $display("FAIL post_reset_op: got lat=%0d wait=%0d, required lat=%0d wait=0", lat, c, LAT_A);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_zero_flag();
    test_round_robin();
    test_mul_latency();
    test_backpressure();
    test_reset_mid_wait();
    repeat (3) @(negedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Shares the single 8-bit ALU between two requesters, for example the instruction datapath and a debug/test port. It arbitrates round-robin and latches the chosen operands and opcode. It holds them stable on the ALU inputs for an opcode-dependent number of cycles, then captures RESULT and ZERO and returns them with a valid/ready response. Sits between the requesters and the ALU instance; one operation is in flight at a time.

Parameters:
LAT_BASIC, 1, wait cycles for SELECT 000/010/011/100/101/110 (must be >=1)
LAT_ADD, 1, wait cycles for SELECT 001 (must be >=1)
LAT_MULT, 3, wait cycles for SELECT 111 (must be >=1)
CNT_W, 3, wait-counter width; must hold max(LAT_*)-1

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-low
REQ0_VALID  in  1  requester 0 has an operation
REQ0_READY  out  1  requester 0 accepted this cycle
REQ0_OP  in  3  ALU SELECT code
REQ0_A  in  8  DATA1 operand
REQ0_B  in  8  DATA2 operand
REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_A, REQ1_B  same as requester 0
RSP0_VALID  out  1  response for requester 0 pending
RSP0_READY  in  1  requester 0 takes response
RSP1_VALID  out  1  response for requester 1 pending
RSP1_READY  in  1  requester 1 takes response
RSP_DATA  out  8  captured ALU result (shared)
RSP_ZERO  out  1  captured zero flag (shared)
ALU_DATA1  out  8  to ALU DATA1
ALU_DATA2  out  8  to ALU DATA2
ALU_SELECT  out  3  to ALU SELECT
ALU_RESULT  in  8  from ALU RESULT
ALU_ZERO  in  1  from ALU ZERO
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE; all outputs and registers 0.
  - Round-robin pointer favours port 0.
  - Any in-flight operation is dropped; no response is issued.
- States:
  - IDLE -> WAIT on accept.
  - WAIT -> RESP when the counter is 0.
  - RESP -> IDLE on RSPx_READY of the owning port.
- Arbitration (combinational, IDLE only):
  - If one port is valid, grant it.
  - If both are valid, grant the port other than the last served.
  - REQx_READY = (state==IDLE) && REQx_VALID && grant==x.
  - REQx_READY may depend on REQx_VALID; VALID must never depend on READY.
  - Outside IDLE, both READY are 0.
- Accept edge E0:
  - Latch OP/A/B into registers driving ALU_SELECT/ALU_DATA1/ALU_DATA2.
  - Latch owner id.
  - Load counter with LAT(op)-1.
  - Update pointer to the owner.
- ALU inputs are registered and held constant from after E0 until the next accept; they are not cleared in RESP/IDLE.
- WAIT: counter decrements each edge. On the edge where counter==0:
  - Capture RSP_DATA=ALU_RESULT.
  - RSP_ZERO=ALU_ZERO if op==001, else RSP_ZERO=0 (the ALU updates ZERO only on add).
  - Assert RSPowner_VALID.
- Response timing: RSPx_VALID rises after edge E0+LAT(op).
- RESP:
  - RSP_DATA/RSP_ZERO/RSPx_VALID are held stable while RSPx_READY=0.
  - The non-owner's RSP_VALID stays 0.
  - On an edge with RSPx_READY=1, drop VALID and go to IDLE.
  - No request is accepted on the same edge; minimum spacing between accepts is LAT+2 cycles.
- Arithmetic: no arithmetic in this block beyond the counter. ALU add wraps modulo 256.
- Simultaneous events:
  - A new request arriving during WAIT/RESP waits; the requester holds VALID and operands.
  - RSP_READY asserted while RSP_VALID=0 is ignored.
- Illegal parameter (LAT_*=0 or CNT_W too small): simulation-time $display error at time 0.

Decomposition:
- Shared header alu_defs.vh holds:
  - opcode constants (OP_FWD=000, OP_ADD=001, OP_AND=010, OP_OR=011, OP_SLL=100, OP_SRA=101, OP_ROR=110, OP_MUL=111);
  - scheduler state encodings (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
- One sub-module, rr_arbiter2: two request bits plus the last-served pointer in, one-hot grant out, combinational.

Test Plan:
- Reset, then REQ0 ADD A=5 B=3 with RSP0_READY=1 -> REQ0_READY high in cycle 1. RSP0_VALID high one cycle after accept with RSP_DATA=8, RSP_ZERO=0. BUSY back to 0 after the response.
- REQ1 ADD A=0x80 B=0x80 -> RSP_DATA=0x00, RSP_ZERO=1, only RSP1_VALID asserted.
- REQ0 and REQ1 both valid right after reset (OR 0x0F|0xF0, AND 0x0F&0xF0) -> port 0 served first (0xFF), then port 1 (0x00). Repeat with both valid again -> port 0 served first again, confirming alternation.
- MUL A=7 B=6 with LAT_MULT=3 -> RSP0_VALID rises exactly 3 edges after accept, RSP_DATA=42, RSP_ZERO=0.
- Backpressure: RSP0_READY held low 5 cycles -> RSP_DATA, RSP_ZERO and RSP0_VALID stable throughout. A pending REQ1 is not accepted until the edge after RSP0_READY goes high.
- RESET pulsed low mid-WAIT of a MUL -> all outputs 0 immediately (asynchronous). No response after release. Next request is served normally.
